// File: rtl/median_send_pkg.sv
// Shared types and helpers for the median operator burst sender.
package median_send_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
        return (len > max) ? max : len;
    endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index counter: synchronous clear has priority over increment.
module burst_beat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/burst_send_ctrl.sv
// Burst sender: streams len pixels from the output buffer into the pixel FIFO and
// writes the side-band word group to all control FIFOs together with beat 0.
module burst_send_ctrl
    import median_send_pkg::*;
#(
    parameter int BUFF_SIZE = 32,
    parameter int CNT_W     = $clog2(BUFF_SIZE) + 1,
    parameter int PX_W      = 8,
    parameter int NUM_SIDE  = 4,
    parameter int SIDE_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CNT_W-1:0]           req_len,
    input  logic [NUM_SIDE*SIDE_W-1:0] req_side,
    input  logic                       abort,
    output logic [CNT_W-1:0]           buf_addr,
    input  logic [PX_W-1:0]            buf_data,
    input  logic                       px_full,
    output logic                       px_wr,
    output logic [PX_W-1:0]            px_dout,
    input  logic [NUM_SIDE-1:0]        side_full,
    output logic [NUM_SIDE-1:0]        side_wr,
    output logic [NUM_SIDE*SIDE_W-1:0] side_dout,
    output logic                       busy,
    output logic [CNT_W-1:0]           send_count,
    output logic                       done,
    output logic                       aborted,
    output logic                       err_len,
    output logic [1:0]                 state_dbg
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(BUFF_SIZE);

    // Request handshake: a request is taken in any cycle where req_valid and
    // req_ready are both high; req_valid/req_len/req_side must hold until then.

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           len_q, len_d;
    logic [NUM_SIDE*SIDE_W-1:0] side_q, side_d;
    logic                       done_q, done_d;
    logic                       aborted_q, aborted_d;
    logic                       err_len_q, err_len_d;

    logic                       cnt_clear;
    logic                       cnt_inc;
    logic [CNT_W-1:0]           count;

    logic                       head_fire;
    logic                       body_fire;
    logic                       beat_wr;
    logic                       at_last;
    logic                       last_beat;
    logic                       ready_int;
    logic                       accept;
    logic                       len_zero;
    logic                       len_over;
    logic [CNT_W-1:0]           len_clamped;

    burst_beat_counter #(
        .CNT_W(CNT_W)
    ) u_beat_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .count(count)
    );

    // len_q - 1 only matters while a burst is active, where len_q >= 1.
    assign at_last   = (count == (len_q - CNT_W'(1)));
    assign head_fire = (state_q == ST_HEAD) && !px_full && (side_full == '0) && !abort;
    assign body_fire = (state_q == ST_BODY) && !px_full && !abort;
    assign beat_wr   = head_fire || body_fire;
    assign last_beat = beat_wr && at_last;
    assign ready_int = !abort && ((state_q == ST_IDLE) || last_beat);
    assign accept    = req_valid && ready_int;

    assign len_zero    = (req_len == '0);
    assign len_over    = (req_len > MAX_LEN);
    assign len_clamped = CNT_W'(clamp_len(int'(req_len), BUFF_SIZE));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        side_d    = side_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        err_len_d = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
            aborted_d = 1'b1;
        end else begin
            if (beat_wr) begin
                if (last_beat) begin
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    state_d = ST_BODY;
                    cnt_inc = 1'b1;
                end
            end
            // Accept can only coincide with a last beat, so it overrides the return to IDLE.
            if (accept) begin
                err_len_d = len_zero || len_over;
                if (!len_zero) begin
                    state_d   = ST_HEAD;
                    cnt_clear = 1'b1;
                    len_d     = len_clamped;
                    side_d    = req_side;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            side_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            side_q    <= side_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_len_q <= err_len_d;
        end
    end

    assign req_ready  = ready_int;
    assign buf_addr   = count;
    assign px_wr      = beat_wr;
    assign px_dout    = buf_data;
    assign side_wr    = {NUM_SIDE{head_fire}};
    assign side_dout  = side_q;
    assign busy       = (state_q != ST_IDLE);
    assign send_count = count;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign err_len    = err_len_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_burst_send_ctrl.sv
// Randomized scoreboard bench for burst_send_ctrl: drivers push expected beats on
// accept, a negedge monitor pops them against what the DUT writes.
module tb_burst_send_ctrl;

    localparam int BUFF_SIZE = 32;
    localparam int CNT_W     = 6;
    localparam int PX_W      = 8;
    localparam int NUM_SIDE  = 4;
    localparam int SIDE_W    = 16;
    localparam int SW        = NUM_SIDE * SIDE_W;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [CNT_W-1:0]     req_len;
    logic [SW-1:0]        req_side;
    logic                 abort;
    logic [CNT_W-1:0]     buf_addr;
    logic [PX_W-1:0]      buf_data;
    logic                 px_full;
    logic                 px_wr;
    logic [PX_W-1:0]      px_dout;
    logic [NUM_SIDE-1:0]  side_full;
    logic [NUM_SIDE-1:0]  side_wr;
    logic [SW-1:0]        side_dout;
    logic                 busy;
    logic [CNT_W-1:0]     send_count;
    logic                 done;
    logic                 aborted;
    logic                 err_len;
    logic [1:0]           state_dbg;

    burst_send_ctrl #(
        .BUFF_SIZE(BUFF_SIZE),
        .CNT_W    (CNT_W),
        .PX_W     (PX_W),
        .NUM_SIDE (NUM_SIDE),
        .SIDE_W   (SIDE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_len   (req_len),
        .req_side  (req_side),
        .abort     (abort),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .px_full   (px_full),
        .px_wr     (px_wr),
        .px_dout   (px_dout),
        .side_full (side_full),
        .side_wr   (side_wr),
        .side_dout (side_dout),
        .busy      (busy),
        .send_count(send_count),
        .done      (done),
        .aborted   (aborted),
        .err_len   (err_len),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- buffer model ----------------
    logic [PX_W-1:0] bufmem [0:BUFF_SIZE-1];
    assign buf_data = (buf_addr < CNT_W'(BUFF_SIZE)) ? bufmem[buf_addr[4:0]] : '0;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [CNT_W-1:0] addr;
        logic [PX_W-1:0]  px;
        logic             head;
        logic             last;
        logic [SW-1:0]    side;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  exp_done = 1'b0;
    logic  exp_abt  = 1'b0;
    logic  exp_err  = 1'b0;
    logic  bp_en    = 1'b0;
    logic  abt_en   = 1'b0;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: reference behaviour expressed over the queue of outstanding beats.
    beat_t b;
    logic  active;
    logic  fire;
    logic  lastp;
    logic  exp_ready;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_done = 1'b0;
            exp_abt  = 1'b0;
            exp_err  = 1'b0;
        end else begin
            chk("done", done, exp_done);
            chk("aborted", aborted, exp_abt);
            chk("err_len", err_len, exp_err);
            exp_done = 1'b0;
            exp_abt  = 1'b0;
            exp_err  = 1'b0;

            active = (exp_q.size() != 0);
            fire   = 1'b0;
            lastp  = 1'b0;
            if (active) begin
                if (exp_q[0].head)
                    fire = !px_full && (side_full == '0) && !abort;
                else
                    fire = !px_full && !abort;
                chk("send_count", send_count, exp_q[0].addr);
                chk("side_dout", side_dout, exp_q[0].side);
            end else begin
                chk("send_count_idle", send_count, 0);
            end
            chk("busy", busy, active);
            chk("state_dbg_busy", state_dbg != 2'd0, active);
            chk("px_wr", px_wr, fire);
            chk("side_wr", side_wr, (fire && exp_q[0].head) ? 4'hF : 4'h0);
            if (fire) begin
                b = exp_q.pop_front();
                chk("buf_addr", buf_addr, b.addr);
                chk("px_dout", px_dout, b.px);
                lastp    = b.last;
                exp_done = b.last;
            end
            exp_ready = !abort && (!active || (fire && lastp));
            chk("req_ready", req_ready, exp_ready);
            if (abort && active) begin
                exp_q.delete();
                exp_abt = 1'b1;
            end
        end
    end

    // ---------------- background stimulus ----------------
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            px_full   = ($urandom_range(0, 3) == 0);
            side_full = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
        if (abt_en) abort = ($urandom_range(0, 24) == 0);
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_req(input int len, input logic [SW-1:0] side);
        int  n    = 0;
        int  eff;
        logic stop = 1'b0;
        req_valid = 1'b1;
        req_len   = CNT_W'(len);
        req_side  = side;
        while (!stop) begin
            @(negedge clk);
            #1;
            if (req_ready) begin
                eff = (len > BUFF_SIZE) ? BUFF_SIZE : len;
                for (int k = 0; k < eff; k++)
                    exp_q.push_back('{addr: CNT_W'(k), px: bufmem[k], head: (k == 0),
                                      last: (k == eff - 1), side: side});
                exp_err = (len == 0) || (len > BUFF_SIZE);
                stop = 1'b1;
            end else if (n >= 400) begin
                chk("req_accept_timeout", req_ready, 1'b1);
                stop = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic abort_at_beat(input int beat);
        int n = 0;
        while (!(exp_q.size() != 0 && exp_q[0].addr == CNT_W'(beat)) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_wait_timeout", n < 200, 1'b1);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_px_wr", px_wr, 0);
        chk("rst_side_wr", side_wr, 0);
        chk("rst_send_count", send_count, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_side_dout", side_dout, 0);
    endtask

    function automatic logic [SW-1:0] rand_side();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int len;
        for (int i = 0; i < BUFF_SIZE; i++) bufmem[i] = 8'($urandom());
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_len   = '0;
        req_side  = '0;
        abort     = 1'b0;
        px_full   = 1'b0;
        side_full = '0;
        #2;
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // basic burst
        send_req(5, rand_side());
        wait_idle();

        // backpressure on side FIFO then pixel FIFO
        send_req(5, rand_side());
        side_full = 4'b0100;
        idle(1);
        side_full = 4'b0000;
        px_full   = 1'b1;
        idle(2);
        px_full   = 1'b0;
        wait_idle();

        // back-to-back bursts
        send_req(3, rand_side());
        send_req(2, rand_side());
        wait_idle();

        // length errors
        send_req(0, rand_side());
        idle(2);
        send_req(40, rand_side());
        wait_idle();
        send_req(BUFF_SIZE, rand_side());
        wait_idle();

        // abort mid burst
        send_req(8, rand_side());
        abort_at_beat(3);
        idle(2);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        idle(1);

        // asynchronous reset mid burst
        send_req(10, rand_side());
        idle(4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_req(1, rand_side());
        wait_idle();

        // randomized traffic with backpressure and aborts
        bp_en  = 1'b1;
        abt_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(BUFF_SIZE + 1, 63);
                default: len = $urandom_range(1, BUFF_SIZE);
            endcase
            send_req(len, rand_side());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        abt_en = 1'b0;
        idle(1);
        abort = 1'b0;
        wait_idle();
        bp_en = 1'b0;
        idle(1);
        px_full   = 1'b0;
        side_full = '0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
